// File: rtl/lcd_text_arbiter.sv
// lcd_text_arbiter
// Shares one lcd_init text sender between N_REQ requesters. A round-robin
// arbiter picks a requester and latches its page. The block then pulses
// sendText and waits for a rising edge on sendingDone. The winner gets an
// ack, or an err if the watchdog expires first. A settle gap always follows.
//
// State table (state | meaning)
//   IDLE      | no transfer; arbitrate among req
//   LATCH     | copy the granted requester's page onto text
//   START     | one-cycle sendText pulse; arm watchdog and done-edge register
//   WAIT_DONE | wait for sendingDone rising edge or watchdog expiry
//   DONE      | one-cycle ack to the winner; advance rr pointer
//   ABORT     | one-cycle err to the winner; advance rr pointer
//   GAP       | settle time before the next grant
//
// Ports
//   CLK          in   system clock, posedge
//   RST_N        in   synchronous reset, active low
//   req          in   level request per requester, held until ack/err
//   req_text     in   page per requester, slot i = [i*8*TEXT_BYTES +: 8*TEXT_BYTES]
//   ack          out  one-cycle pulse, page sent
//   err          out  one-cycle pulse, transfer timed out
//   grant        out  one-hot owner from LATCH through DONE/ABORT
//   busy         out  high in every state except IDLE
//   sendText     out  one-cycle start pulse to lcd_init
//   text         out  latched page, stable while busy
//   sendingDone  in   completion from lcd_init; level or pulse, rising edge used
module lcd_text_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TEXT_BYTES  = 32,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int GAP_CYC     = 1000
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*8*TEXT_BYTES-1:0] req_text,
    output logic [N_REQ-1:0]              ack,
    output logic [N_REQ-1:0]              err,
    output logic [N_REQ-1:0]              grant,
    output logic                          busy,
    output logic                          sendText,
    output logic [8*TEXT_BYTES-1:0]       text,
    input  logic                          sendingDone
);

    localparam int W    = 8 * TEXT_BYTES;
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // The timer also counts out the gap, so it must be wide enough for both.
    localparam int TMAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_START, S_WAIT_DONE, S_DONE, S_ABORT, S_GAP
    } state_t;

    state_t            state, state_next;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   gidx;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_inc;
    logic              done_q;
    logic              done_rise;
    logic              pick_found;
    logic [IDXW-1:0]   pick_idx;

    assign timer_inc = timer + TW'(1);
    assign done_rise = sendingDone & ~done_q;

    // Search from ptr upward with wrap. The scan runs in reverse order, so
    // the last hit written is the first requester at or after ptr.
    always_comb begin
        int c;
        pick_found = 1'b0;
        pick_idx   = '0;
        c          = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            if (c >= N_REQ) c = c - N_REQ;
            if (req[c]) begin
                pick_found = 1'b1;
                pick_idx   = IDXW'(c);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (pick_found) state_next = S_LATCH;
            S_LATCH:     state_next = S_START;
            S_START:     state_next = S_WAIT_DONE;
            // The compare uses the incremented count. ABORT is therefore
            // the TIMEOUT_CYC-th cycle after START. A done edge in the same
            // cycle takes priority.
            S_WAIT_DONE: begin
                if (done_rise)
                    state_next = S_DONE;
                else if (timer_inc == TW'(TIMEOUT_CYC - 1))
                    state_next = S_ABORT;
            end
            S_DONE:      state_next = S_GAP;
            S_ABORT:     state_next = S_GAP;
            S_GAP: begin
                if (GAP_CYC == 0 || timer == TW'(GAP_CYC - 1))
                    state_next = S_IDLE;
            end
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        sendText = (state == S_START);
        ack      = (state == S_DONE)  ? grant : '0;
        err      = (state == S_ABORT) ? grant : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= S_IDLE;
            grant  <= '0;
            gidx   <= '0;
            ptr    <= '0;
            text   <= '0;
            timer  <= '0;
            done_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant <= N_REQ'(1) << pick_idx;
                        gidx  <= pick_idx;
                    end
                end
                S_LATCH: text <= req_text[gidx*W +: W];
                S_START: begin
                    timer  <= '0;
                    done_q <= sendingDone;
                end
                S_WAIT_DONE: begin
                    timer  <= timer_inc;
                    done_q <= sendingDone;
                end
                S_DONE, S_ABORT: begin
                    ptr   <= (gidx == IDXW'(N_REQ - 1)) ? '0 : gidx + IDXW'(1);
                    grant <= '0;
                    timer <= '0;
                end
                S_GAP:   timer <= timer_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_arbiter.sv
module tb_lcd_text_arbiter;

    localparam int N_REQ       = 4;
    localparam int TEXT_BYTES  = 32;
    localparam int TIMEOUT_CYC = 100;
    localparam int GAP_CYC     = 8;
    localparam int GD          = GAP_CYC + 3;   // ack/err -> next sendText

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [3:0]   req;
    logic [1023:0] req_text;
    logic [3:0]   ack, err, grant;
    logic         busy, sendText;
    logic [255:0] text;
    logic         sendingDone;
    logic         done_pulse;
    logic         done_level;

    logic [255:0] pg [4];

    assign sendingDone = done_pulse | done_level;
    assign req_text    = {pg[3], pg[2], pg[1], pg[0]};

    lcd_text_arbiter #(
        .N_REQ(N_REQ), .TEXT_BYTES(TEXT_BYTES),
        .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .req(req), .req_text(req_text),
        .ack(ack), .err(err), .grant(grant), .busy(busy),
        .sendText(sendText), .text(text), .sendingDone(sendingDone)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int           kind;       // 0 sendText, 1 ack, 2 err
        logic [3:0]   vec;
        int           delta;      // cycles from base event, -1 = don't care
        bit           from_mark;  // base = mark_cyc (req drive) else last event
        logic [255:0] txt;
        string        nm;
    } exp_t;

    exp_t sbq[$];

    int compared   = 0;
    int mismatched = 0;
    int n_send = 0, n_ack = 0, n_err = 0;
    int last_evt = 0;
    int mark_cyc = 0;
    int tmo_cnt = 0, tmo_seen = 0;
    bit end_chk = 0, end_done = 0;
    int resp_delay = 0;

    task automatic push(input int kind, input logic [3:0] vec, input int delta,
                        input bit from_mark, input logic [255:0] txt, input string nm);
        exp_t e;
        e.kind = kind; e.vec = vec; e.delta = delta;
        e.from_mark = from_mark; e.txt = txt; e.nm = nm;
        sbq.push_back(e);
    endtask

    task automatic wait_evt(input int kind, input int target, input int budget);
        int n;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK); #2;
            n = (kind == 0) ? n_send : (kind == 1) ? n_ack : n_err;
            if (n >= target) return;
        end
        tmo_cnt++;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        int k, d, base;
        logic [3:0] v;
        bit bad;
        forever begin
            @(posedge CLK); #1;
            if (tmo_cnt != tmo_seen) begin
                tmo_seen++;
                compared++; mismatched++;
                $display("FAIL wait_timeout#%0d: expected event did not arrive in budget (cycle %0d)", tmo_seen, cyc);
            end
            if (end_chk && !end_done) begin
                end_done = 1;
                compared++;
                if (sbq.size() != 0) begin
                    mismatched++;
                    $display("FAIL leftover: %0d expected events never seen, required 0", sbq.size());
                end
            end
            if (!RST_N) begin
                compared++;
                if (grant != 0 || busy || sendText || ack != 0 || err != 0) begin
                    mismatched++;
                    $display("FAIL reset_quiet: grant=%b busy=%b sendText=%b ack=%b err=%b, required all 0",
                             grant, busy, sendText, ack, err);
                end
            end else if (sendText || ack != 0 || err != 0) begin
                if (sendText && ack == 0 && err == 0)      begin k = 0; v = grant; end
                else if (!sendText && ack != 0 && err == 0) begin k = 1; v = ack; end
                else if (!sendText && ack == 0 && err != 0) begin k = 2; v = err; end
                else begin k = 3; v = ack | err; end
                compared++;
                if (sbq.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_event: kind=%0d vec=%b at cycle %0d, required none", k, v, cyc);
                end else begin
                    e = sbq.pop_front();
                    base = e.from_mark ? mark_cyc : last_evt;
                    d = cyc - base;
                    bad = (e.kind != k) || (e.vec != v) || (e.delta >= 0 && d != e.delta)
                          || (k == 0 && text != e.txt);
                    if (bad) begin
                        mismatched++;
                        $display("FAIL %s: kind=%0d vec=%b delta=%0d, required kind=%0d vec=%b delta=%0d",
                                 e.nm, k, v, d, e.kind, e.vec, e.delta);
                        if (k == 0 && text != e.txt)
                            $display("FAIL %s_text: text=%h required %h", e.nm, text, e.txt);
                    end
                end
                last_evt = cyc;
                if (k == 0) n_send++;
                if (k == 1) n_ack++;
                if (k == 2) n_err++;
            end
        end
    end

    // lcd_init stand-in: one-cycle done pulse resp_delay cycles after sendText
    initial begin
        int dl;
        done_pulse = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (sendText && resp_delay > 0) begin
                dl = resp_delay;
                repeat (dl) @(posedge CLK);
                @(negedge CLK); done_pulse = 1'b1;
                @(negedge CLK); done_pulse = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        pg[0] = {32{8'h30}};
        pg[1] = {32{8'h31}};
        pg[2] = "HELLO, PAGE TWO - LCD ARBITER OK";
        pg[3] = {32{8'h33}};
        RST_N = 1'b0; req = 4'b1111; done_level = 1'b0; resp_delay = 10;

        // Reset held with all requests up: outputs stay quiet
        repeat (3) @(posedge CLK);

        // Fairness: all held, grants 0,1,2,3,0, done 10 cycles after each start
        push(0, 4'b0001, 2,  1, pg[0], "rr_send0");
        push(1, 4'b0001, 11, 0, '0,    "rr_ack0");
        push(0, 4'b0010, GD, 0, pg[1], "rr_send1");
        push(1, 4'b0010, 11, 0, '0,    "rr_ack1");
        push(0, 4'b0100, GD, 0, pg[2], "rr_send2");
        push(1, 4'b0100, 11, 0, '0,    "rr_ack2");
        push(0, 4'b1000, GD, 0, pg[3], "rr_send3");
        push(1, 4'b1000, 11, 0, '0,    "rr_ack3");
        push(0, 4'b0001, GD, 0, pg[0], "rr_send0b");
        push(1, 4'b0001, 11, 0, '0,    "rr_ack0b");
        @(negedge CLK); mark_cyc = cyc; RST_N = 1'b1;
        wait_evt(0, 5, 400);
        @(negedge CLK); req = 4'b0000;          // drop after grant: ack still due
        wait_evt(1, 5, 100);
        repeat (GAP_CYC + 4) @(posedge CLK);

        // Single request, done 50 cycles after sendText
        resp_delay = 50;
        push(0, 4'b0100, 2,  1, pg[2], "single_send2");
        push(1, 4'b0100, 51, 0, '0,    "single_ack2");
        @(negedge CLK); mark_cyc = cyc; req = 4'b0100;
        wait_evt(1, 6, 200);
        @(negedge CLK); req = 4'b0000;
        repeat (GAP_CYC + 4) @(posedge CLK);

        // Watchdog: no done, err 100 cycles after start; next req after gap
        resp_delay = 0;
        push(0, 4'b0010, 2,           1, pg[1], "wd_send1");
        push(2, 4'b0010, TIMEOUT_CYC, 0, '0,    "wd_err1");
        push(0, 4'b0001, GD,          0, pg[0], "wd_next_send0");
        push(1, 4'b0001, 8,           0, '0,    "wd_next_ack0");
        @(negedge CLK); mark_cyc = cyc; req = 4'b0010;
        wait_evt(0, 7, 50);
        @(negedge CLK); req = 4'b0000;
        wait_evt(2, 1, 200);
        @(negedge CLK); req = 4'b0001; resp_delay = 7;
        wait_evt(1, 7, 100);
        @(negedge CLK); req = 4'b0000; resp_delay = 0;
        repeat (GAP_CYC + 4) @(posedge CLK);

        // Level-mode done held high across START: only the next rise counts
        @(negedge CLK); done_level = 1'b1;
        push(0, 4'b0100, 2,  1, pg[2], "lvl_send2");
        push(1, 4'b0100, 26, 0, '0,    "lvl_ack2");
        @(negedge CLK); mark_cyc = cyc; req = 4'b0100;
        wait_evt(0, 9, 50);
        repeat (20) @(posedge CLK);
        @(negedge CLK); done_level = 1'b0; req = 4'b0000;
        repeat (5) @(posedge CLK);
        @(negedge CLK); done_level = 1'b1;
        wait_evt(1, 8, 50);
        @(negedge CLK); done_level = 1'b0;
        repeat (GAP_CYC + 4) @(posedge CLK);

        // Reset mid WAIT_DONE; pointer (3 before reset) must return to 0
        push(0, 4'b1000, 2, 1, pg[3], "rst_send3");
        @(negedge CLK); mark_cyc = cyc; req = 4'b1000;
        wait_evt(0, 10, 50);
        repeat (10) @(posedge CLK);
        @(negedge CLK); RST_N = 1'b0; req = 4'b0000;
        @(negedge CLK); RST_N = 1'b1;
        resp_delay = 5;
        push(0, 4'b0001, 2, 1, pg[0], "post_rst_send0");
        push(1, 4'b0001, 6, 0, '0,    "post_rst_ack0");
        @(negedge CLK); mark_cyc = cyc; req = 4'b1001;
        wait_evt(0, 11, 50);
        @(negedge CLK); req = 4'b0000;
        wait_evt(1, 9, 50);
        repeat (GAP_CYC + 4) @(posedge CLK);

        @(negedge CLK); end_chk = 1;
        repeat (3) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
